glift_serial_add_ctrl: RTL and testbench

//  Bit-serial adder sequencer built around one shared GLIFT full-adder cell (fa).
//  It accepts WIDTH-bit operands with per-bit taint vectors.
//  It feeds fa one bit per cycle, LSB first, through a registered carry/carry-taint loop.
//  It returns sum, sum taint, carry-out and carry-out taint with a start/busy/done handshake.

---
 rtl/glift_serial_add_ctrl.sv | 170 +++++++++++++++++
 tb/tb_glift_serial_add_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/glift_serial_add_ctrl.sv
// Bit-serial GLIFT adder: one shared taint-tracking full-adder cell fed LSB first via a registered carry loop.
// Optional macro GLIFT_TAINT_SUMMARY_EN adds a registered taint_any output (|sum_t | cout_t).

module glift_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  input  logic i_a_t,
  input  logic i_b_t,
  input  logic i_c_t,
  output logic o_s,
  output logic o_s_t,
  output logic o_c,
  output logic o_c_t
);
  logic w_x1, w_x1_t, w_g1, w_g1_t, w_g2, w_g2_t;

  // Two half adders; XOR taint is the OR of input taints, AND taint is the precise GLIFT rule.
  assign w_x1   = i_a ^ i_b;
  assign w_x1_t = i_a_t | i_b_t;
  assign w_g1   = i_a & i_b;
  assign w_g1_t = (i_a & i_b_t) | (i_b & i_a_t) | (i_a_t & i_b_t);

  assign o_s    = w_x1 ^ i_c;
  assign o_s_t  = w_x1_t | i_c_t;
  assign w_g2   = w_x1 & i_c;
  assign w_g2_t = (w_x1 & i_c_t) | (i_c & w_x1_t) | (w_x1_t & i_c_t);

  // Carry merge: a tainted term only matters when the other term is 0.
  assign o_c    = w_g1 | w_g2;
  assign o_c_t  = (~w_g1 & w_g2_t) | (~w_g2 & w_g1_t) | (w_g1_t & w_g2_t);
endmodule

module glift_serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] a_t,
  input  logic [WIDTH-1:0] b_t,
  input  logic             cin,
  input  logic             cin_t,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] sum_t,
  output logic             cout,
  output logic             cout_t
`ifdef GLIFT_TAINT_SUMMARY_EN
  ,
  output logic             taint_any
`endif
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_a_t_sr, r_b_t_sr;
  logic [WIDTH-1:0] r_res_sr, r_res_t_sr;
  logic [WIDTH-1:0] r_sum, r_sum_t;
  logic             r_carry, r_carry_t, r_cout, r_cout_t;
  logic [CW-1:0]    r_cnt;
  logic             w_fa_s, w_fa_s_t, w_fa_c, w_fa_c_t, w_last;
  logic [WIDTH-1:0] w_res_next, w_res_t_next;

  glift_fa u_fa (
    .i_a   (r_a_sr[0]),
    .i_b   (r_b_sr[0]),
    .i_c   (r_carry),
    .i_a_t (r_a_t_sr[0]),
    .i_b_t (r_b_t_sr[0]),
    .i_c_t (r_carry_t),
    .o_s   (w_fa_s),
    .o_s_t (w_fa_s_t),
    .o_c   (w_fa_c),
    .o_c_t (w_fa_c_t)
  );

  assign w_last       = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));
  assign w_res_next   = {w_fa_s,   r_res_sr[WIDTH-1:1]};
  assign w_res_t_next = {w_fa_s_t, r_res_t_sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_a_t_sr   <= '0;
      r_b_t_sr   <= '0;
      r_res_sr   <= '0;
      r_res_t_sr <= '0;
      r_carry    <= 1'b0;
      r_carry_t  <= 1'b0;
      r_cnt      <= '0;
      r_sum      <= '0;
      r_sum_t    <= '0;
      r_cout     <= 1'b0;
      r_cout_t   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sr    <= a;
            r_b_sr    <= b;
            r_a_t_sr  <= a_t;
            r_b_t_sr  <= b_t;
            r_carry   <= cin;
            r_carry_t <= cin_t;
            r_cnt     <= '0;
          end
        end
        S_RUN: begin
          r_a_sr     <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr     <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_a_t_sr   <= {1'b0, r_a_t_sr[WIDTH-1:1]};
          r_b_t_sr   <= {1'b0, r_b_t_sr[WIDTH-1:1]};
          r_res_sr   <= w_res_next;
          r_res_t_sr <= w_res_t_next;
          r_carry    <= w_fa_c;
          r_carry_t  <= w_fa_c_t;
          r_cnt      <= r_cnt + CW'(1);
          // Visible results only move on the final bit, so they hold across a new operation.
          if (w_last) begin
            r_sum    <= w_res_next;
            r_sum_t  <= w_res_t_next;
            r_cout   <= w_fa_c;
            r_cout_t <= w_fa_c_t;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef GLIFT_TAINT_SUMMARY_EN
  logic r_taint_any;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_taint_any <= 1'b0;
    else if (w_last) r_taint_any <= (|w_res_t_next) | w_fa_c_t;
  end

  assign taint_any = r_taint_any;
`endif

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign sum    = r_sum;
  assign sum_t  = r_sum_t;
  assign cout   = r_cout;
  assign cout_t = r_cout_t;
endmodule

// File: tb/tb_glift_serial_add_ctrl.sv
// Self-checking bench for glift_serial_add_ctrl: directed spec cases plus randomized operations
// checked against an arithmetic/gate-rule reference model.
module tb_glift_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n, start, cin, cin_t;
  logic [W-1:0] a, b, a_t, b_t;
  logic         busy, done, cout, cout_t;
  logic [W-1:0] sum, sum_t;
`ifdef GLIFT_TAINT_SUMMARY_EN
  logic         taint_any;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] held_sum, held_sum_t;
  logic         held_cout, held_cout_t;

  glift_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .a_t    (a_t),
    .b_t    (b_t),
    .cin    (cin),
    .cin_t  (cin_t),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .sum_t  (sum_t),
    .cout   (cout),
    .cout_t (cout_t)
`ifdef GLIFT_TAINT_SUMMARY_EN
    ,
    .taint_any (taint_any)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic and_t(input logic x, input logic xt, input logic y, input logic yt);
    return (x & yt) | (y & xt) | (xt & yt);
  endfunction

  function automatic logic or_t(input logic x, input logic xt, input logic y, input logic yt);
    return (~x & yt) | (~y & xt) | (xt & yt);
  endfunction

  // Values from plain addition; taint from the gate-level GLIFT rules applied bit by bit.
  task automatic model(input logic [W-1:0] ia, ib, iat, ibt, input logic ici, icit,
                       output logic [W-1:0] s, st, output logic co, cot);
    logic [W:0] tot;
    logic c, ct, x, xt, g1, g1t, g2, g2t;
    tot = {1'b0, ia} + {1'b0, ib} + {{W{1'b0}}, ici};
    s   = tot[W-1:0];
    co  = tot[W];
    c   = ici;
    ct  = icit;
    st  = '0;
    for (int i = 0; i < W; i++) begin
      x     = ia[i] ^ ib[i];
      xt    = iat[i] | ibt[i];
      g1    = ia[i] & ib[i];
      g1t   = and_t(ia[i], iat[i], ib[i], ibt[i]);
      st[i] = xt | ct;
      g2    = x & c;
      g2t   = and_t(x, xt, c, ct);
      ct    = or_t(g1, g1t, g2, g2t);
      c     = g1 | g2;
    end
    cot = ct;
  endtask

  task automatic scramble();
    a = W'($urandom); b = W'($urandom); a_t = W'($urandom); b_t = W'($urandom);
    cin = 1'($urandom); cin_t = 1'($urandom);
  endtask

  // Call at a negedge; returns at the negedge one cycle after done, ready for a back-to-back start.
  task automatic run_op(input logic [W-1:0] ia, ib, iat, ibt, input logic ici, icit,
                        input int glitch_at);
    logic [W-1:0] es, est;
    logic eco, ecot;
    int busy_cnt;
    bit seen;
    model(ia, ib, iat, ibt, ici, icit, es, est, eco, ecot);
    a = ia; b = ib; a_t = iat; b_t = ibt; cin = ici; cin_t = icit;
    start = 1'b1;
    busy_cnt = 0;
    seen = 1'b0;
    for (int k = 1; k <= 4 * W && !seen; k++) begin
      @(negedge clk);
      start = (k == glitch_at);
      if (k == 1 || k == glitch_at) scramble();
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        chk("latency", 64'(k), 64'(W + 1));
        chk("busy_cycles", 64'(busy_cnt), 64'(W + 1));
        chk("sum", 64'(sum), 64'(es));
        chk("sum_t", 64'(sum_t), 64'(est));
        chk("cout", 64'({cout_t, cout}), 64'({ecot, eco}));
`ifdef GLIFT_TAINT_SUMMARY_EN
        chk("taint_any", 64'(taint_any), 64'((|est) | ecot));
`endif
      end else begin
        chk("hold", 64'({sum_t, sum, cout_t, cout}),
            64'({held_sum_t, held_sum, held_cout_t, held_cout}));
      end
    end
    if (!seen) chk("done_timeout", 64'(0), 64'(1));
    held_sum = es; held_sum_t = est; held_cout = eco; held_cout_t = ecot;
    @(negedge clk);
    start = 1'b0;
    chk("idle_after", 64'({busy, done}), 64'(0));
    $display("[TB] op a=%h b=%h a_t=%h b_t=%h cin=%b cin_t=%b -> sum=%h sum_t=%h cout=%b cout_t=%b",
             ia, ib, iat, ibt, ici, icit, sum, sum_t, cout, cout_t);
  endtask

  initial begin
    int dones;
    rst_n = 1'b0;
    start = 1'b1;
    scramble();
    held_sum = '0; held_sum_t = '0; held_cout = 1'b0; held_cout_t = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    chk("reset_outputs", 64'({busy, done, sum, sum_t, cout, cout_t}), 64'(0));
    repeat (3) @(negedge clk);
    chk("idle_no_op", 64'({busy, done, sum, cout}), 64'(0));

    run_op(8'h5A, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    chk("spec_5a_3c", 64'({cout_t, cout, sum_t, sum}), 64'({2'b00, 8'h00, 8'h96}));
    run_op(8'hFF, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    chk("spec_wrap", 64'({cout, sum}), 64'({1'b1, 8'h00}));
    run_op(8'h00, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 0);
    chk("spec_taint_lsb", 64'({cout_t, sum_t}), 64'({1'b0, 8'h01}));
    run_op(8'h01, 8'h7F, 8'h00, 8'h01, 1'b0, 1'b0, 0);
    chk("spec_taint_ripple", 64'({cout_t, sum_t}), 64'({1'b0, 8'hFF}));
    run_op(8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 3);
    chk("start_while_busy", 64'(sum), 64'(8'h47));

    // Abort an operation in its fourth RUN cycle.
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; a_t = 8'h00; b_t = 8'h00; cin = 1'b0; cin_t = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrun_reset", 64'({busy, done, sum, sum_t, cout, cout_t}), 64'(0));
    held_sum = '0; held_sum_t = '0; held_cout = 1'b0; held_cout_t = 1'b0;
    dones = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("no_done_after_abort", 64'(dones), 64'(0));
    run_op(8'hC3, 8'h5E, 8'h10, 8'h01, 1'b1, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), W'($urandom & $urandom), W'($urandom & $urandom),
             1'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(0, W + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
